hazard_stall_unit: RTL and testbench

Parametrised load-use hazard and stall controller for the 19-bit CPU pipeline, between the ID and EX stages. It generalises the combinational load-use check with a configurable register-address width, a multi-cycle load stall driven by a counter and a data-memory ready handshake, and operand-use qualifiers. It also adds branch-flush control and a saturating stall-cycle performance counter. It drives PC write enable, IF/ID write enable, IF/ID flush and the ID/EX bubble.

---
 rtl/hazard_stall_unit.sv | 107 ++++++++++
 tb/tb_hazard_stall_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use hazard detection and stall control between ID and EX.
// A load-use match stalls the front end in the detection cycle with zero latency.
// The stall is held for at least STALL_CYCLES cycles and until data memory
// reports the load data ready. A taken branch flushes IF/ID and overrides any
// stall. A saturating counter records every cycle in which the PC is held.
module hazard_stall_unit #(
  parameter int REG_W        = 3,
  parameter int STALL_CYCLES = 1,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_memread,
  input  logic [REG_W-1:0]  EX_rt,
  input  logic [REG_W-1:0]  ID_rs,
  input  logic [REG_W-1:0]  ID_rt,
  input  logic              ID_rs_used,
  input  logic              ID_rt_used,
  input  logic              EX_branch_taken,
  input  logic              dmem_ready,
  input  logic              perf_clear,
  output logic              hazard,
  output logic              PCwrite,
  output logic              IF_IDwrite,
  output logic              IF_IDflush,
  output logic              stall_active,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam int         CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STALL_CYCLES - 1);
  // With a single-cycle minimum the detection cycle alone can cover the load.
  localparam bit         ONE_CYC = (STALL_CYCLES == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             match;

  // Register 0 is not special: it is compared like any other register.
  assign match = EX_memread &
                 ((ID_rs_used & (EX_rt == ID_rs)) | (ID_rt_used & (EX_rt == ID_rt)));

  // Output decode: branch beats stall; while in STALL the match is not looked at.
  always_comb begin
    hazard     = 1'b0;
    PCwrite    = 1'b1;
    IF_IDwrite = 1'b1;
    IF_IDflush = 1'b0;
    if (!rst) begin
      if (EX_branch_taken) begin
        IF_IDflush = 1'b1;
        hazard     = 1'b1;
      end else if (state == STALL || match) begin
        hazard     = 1'b1;
        PCwrite    = 1'b0;
        IF_IDwrite = 1'b0;
      end
    end
  end

  assign stall_active = !rst && (state == STALL);

  // Stall FSM: cnt holds remaining minimum cycles; exit needs cnt<=1 and ready data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!EX_branch_taken && match && !(ONE_CYC && dmem_ready)) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          if (EX_branch_taken) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt <= CNT_W'(1) && dmem_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of PC-hold cycles; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (perf_clear)
      stall_count <= '0;
    else if (!PCwrite && stall_count != '1)
      stall_count <= stall_count + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (STALL_CYCLES=1/PERF_W=4 and
// STALL_CYCLES=3/PERF_W=16) share stimulus and are compared each cycle against
// a model that tracks elapsed cycles since hazard detection.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst, EX_memread, ID_rs_used, ID_rt_used, EX_branch_taken, dmem_ready, perf_clear;
  logic [2:0] EX_rt, ID_rs, ID_rt;
  logic       hz[2], pw[2], iw[2], fl[2], sa[2];
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance
  int sc[2]   = '{1, 3};
  int maxc[2] = '{15, 65535};
  bit ins[2];
  int k[2];
  int pc[2];

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_W(3), .STALL_CYCLES(1), .PERF_W(4)) dut_a (
    .clk(clk), .rst(rst), .EX_memread(EX_memread), .EX_rt(EX_rt), .ID_rs(ID_rs),
    .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .EX_branch_taken(EX_branch_taken), .dmem_ready(dmem_ready), .perf_clear(perf_clear),
    .hazard(hz[0]), .PCwrite(pw[0]), .IF_IDwrite(iw[0]), .IF_IDflush(fl[0]),
    .stall_active(sa[0]), .stall_count(cnt_a));

  hazard_stall_unit #(.REG_W(3), .STALL_CYCLES(3), .PERF_W(16)) dut_b (
    .clk(clk), .rst(rst), .EX_memread(EX_memread), .EX_rt(EX_rt), .ID_rs(ID_rs),
    .ID_rt(ID_rt), .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .EX_branch_taken(EX_branch_taken), .dmem_ready(dmem_ready), .perf_clear(perf_clear),
    .hazard(hz[1]), .PCwrite(pw[1]), .IF_IDwrite(iw[1]), .IF_IDflush(fl[1]),
    .stall_active(sa[1]), .stall_count(cnt_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs just after, advance model at posedge.
  task automatic step(input bit r, input bit mr, input int ert, input int rs, input int rt,
                      input bit rsu, input bit rtu, input bit br, input bit rdy, input bit clr);
    bit         m;
    bit         pcw[2];
    logic [4:0] eo, go;
    @(negedge clk);
    rst = r; EX_memread = mr; EX_rt = 3'(ert); ID_rs = 3'(rs); ID_rt = 3'(rt);
    ID_rs_used = rsu; ID_rt_used = rtu; EX_branch_taken = br; dmem_ready = rdy; perf_clear = clr;
    #1;
    m = mr && ((rsu && ert == rs) || (rtu && ert == rt));
    for (int d = 0; d < 2; d++) begin
      if (r) begin ins[d] = 0; k[d] = 0; pc[d] = 0; end
      if (r)                 eo = 5'b01100;
      else if (br)           eo = {4'b1111, ins[d]};
      else if (ins[d] || m)  eo = {4'b1000, ins[d]};
      else                   eo = 5'b01100;
      pcw[d] = eo[3];
      go = {hz[d], pw[d], iw[d], fl[d], sa[d]};
      chk(d == 0 ? "outs_sc1" : "outs_sc3", 32'(go), 32'(eo));
      chk(d == 0 ? "cnt_sc1" : "cnt_sc3", d == 0 ? 32'(cnt_a) : 32'(cnt_b), 32'(pc[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        ins[d] = 0; k[d] = 0; pc[d] = 0;
      end else begin
        if (clr) pc[d] = 0;
        else if (!pcw[d] && pc[d] < maxc[d]) pc[d]++;
        // A stall started at elapsed cycle 0 ends after cycle k when k+1 >= STALL_CYCLES and data is ready.
        if (!ins[d]) begin
          if (!br && m && !(sc[d] <= 1 && rdy)) begin ins[d] = 1; k[d] = 1; end
        end else if (br || (k[d] + 1 >= sc[d] && rdy)) begin
          ins[d] = 0; k[d] = 0;
        end else begin
          k[d]++;
        end
      end
    end
  endtask

  initial begin
    // Reset and directed cases
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 4, 0, 4, 0, 1, 0, 1, 0);     // outputs idle while in reset
    step(0, 1, 4, 0, 4, 0, 1, 0, 1, 0);     // load-use on rt
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 3, 2, 1, 1, 0, 1, 0);     // no match
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);     // r0 but unused operands
    step(0, 1, 0, 0, 5, 1, 0, 0, 1, 0);     // r0 used -> stall
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 2, 2, 0, 1, 0, 0, 0, 0);     // dmem not ready
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 6, 6, 0, 1, 0, 1, 1, 0);     // branch together with match
    step(0, 1, 6, 6, 0, 1, 0, 0, 1, 0);     // 3-cycle stall, branch mid-way
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 7, 7, 7, 1, 1, 0, 0, 0);     // reset mid-stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 4, 4, 4, 1, 1, 0, 0, 0);  // saturate 4-bit count
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);     // perf_clear
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Randomised traffic with a small register range to provoke frequent matches
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 3,
           $urandom_range(0, 59) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
